// File: rtl/cpu_rf_pkg.sv
// Shared definitions for the integer register file slice.
// Provides default geometry, derived address/counter widths and the
// helper that locates a read port's field inside a packed port bus.
package cpu_rf_pkg;

    localparam int unsigned RF_DATA_W = 32;
    localparam int unsigned RF_REG_N  = 32;
    localparam int unsigned RF_ADDR_W = $clog2(RF_REG_N);
    localparam int unsigned RF_CNT_W  = $clog2(RF_REG_N + 1);

    // LSB position of port p's field in a bus packed as [p*width +: width].
    function automatic int unsigned rd_lsb(input int unsigned port, input int unsigned width);
        return port * width;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard.
// Ports:
//   i_clk, i_rst           clock, async active-high reset
//   i_wr_en, i_wr_addr     writeback clears the destination's busy bit
//   i_rsv_en, i_rsv_addr   reservation request from issue
//   i_flush                clears every reservation
//   o_rsv_ok               reservation accepted this cycle (combinational)
//   o_busy                 busy vector, one bit per register
//   o_busy_cnt             number of set busy bits
module rf_scoreboard
    import cpu_rf_pkg::*;
#(
    parameter int unsigned REG_N    = RF_REG_N,
    parameter int unsigned ADDR_W   = $clog2(REG_N),
    parameter int unsigned CNT_W    = $clog2(REG_N + 1),
    parameter int unsigned ZERO_REG = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic              i_rsv_en,
    input  logic [ADDR_W-1:0] i_rsv_addr,
    input  logic              i_flush,
    output logic              o_rsv_ok,
    output logic [REG_N-1:0]  o_busy,
    output logic [CNT_W-1:0]  o_busy_cnt
);

    logic [REG_N-1:0] busy;
    logic [CNT_W-1:0] cnt;
    logic             rsv_set;
    logic             dec;

    always_comb begin
        o_rsv_ok = i_rsv_en && !i_flush &&
                   (!busy[i_rsv_addr] || (i_wr_en && i_wr_addr == i_rsv_addr));
        rsv_set  = o_rsv_ok && !(ZERO_REG != 0 && i_rsv_addr == '0);
        dec      = i_wr_en && busy[i_wr_addr];
    end

    // An accepted reservation always targets a bit that is 0 after this
    // cycle's writeback clear, so it always counts +1; a same-address
    // write of a busy register nets to zero.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            busy <= '0;
            cnt  <= '0;
        end else if (i_flush) begin
            busy <= '0;
            cnt  <= '0;
        end else begin
            if (i_wr_en) busy[i_wr_addr] <= 1'b0;
            if (rsv_set) busy[i_rsv_addr] <= 1'b1;
            case ({rsv_set, dec})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign o_busy     = busy;
    assign o_busy_cnt = cnt;

endmodule

// File: rtl/regfile_sb.sv
// Parametrised integer register file with N combinational read ports,
// one writeback port, write-to-read bypass, optional hardwired zero
// register and a busy scoreboard for RAW/WAW hazard tracking.
// Ports:
//   i_clk, i_rst           clock, async active-high reset
//   i_rd_addr/o_rd_data    packed read ports, port p at [p*W +: W]
//   o_rd_busy              addressed register has a pending reservation
//   i_wr_en/addr/data      writeback
//   i_rsv_en/addr, o_rsv_ok reservation request / acceptance
//   i_flush                drop all reservations
//   o_busy_cnt             number of reserved registers
module regfile_sb
    import cpu_rf_pkg::*;
#(
    parameter int unsigned DATA_W   = RF_DATA_W,
    parameter int unsigned REG_N    = RF_REG_N,
    parameter int unsigned ADDR_W   = $clog2(REG_N),
    parameter int unsigned RD_PORTS = 2,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [RD_PORTS*ADDR_W-1:0]   i_rd_addr,
    output logic [RD_PORTS*DATA_W-1:0]   o_rd_data,
    output logic [RD_PORTS-1:0]          o_rd_busy,
    input  logic                         i_wr_en,
    input  logic [ADDR_W-1:0]            i_wr_addr,
    input  logic [DATA_W-1:0]            i_wr_data,
    input  logic                         i_rsv_en,
    input  logic [ADDR_W-1:0]            i_rsv_addr,
    output logic                         o_rsv_ok,
    input  logic                         i_flush,
    output logic [$clog2(REG_N+1)-1:0]   o_busy_cnt
);

    localparam int unsigned CNT_W = $clog2(REG_N + 1);

    logic [DATA_W-1:0] regs [REG_N];
    logic [REG_N-1:0]  busy;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              bsy;

    rf_scoreboard #(
        .REG_N    (REG_N),
        .ADDR_W   (ADDR_W),
        .CNT_W    (CNT_W),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_wr_en    (i_wr_en),
        .i_wr_addr  (i_wr_addr),
        .i_rsv_en   (i_rsv_en),
        .i_rsv_addr (i_rsv_addr),
        .i_flush    (i_flush),
        .o_rsv_ok   (o_rsv_ok),
        .o_busy     (busy),
        .o_busy_cnt (o_busy_cnt)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < REG_N; i++) regs[i] <= '0;
        end else if (i_wr_en && !(ZERO_REG != 0 && i_wr_addr == '0)) begin
            regs[i_wr_addr] <= i_wr_data;
        end
    end

    // Zero-register masking is applied last so it overrides the bypass.
    always_comb begin
        o_rd_data = '0;
        o_rd_busy = '0;
        addr      = '0;
        data      = '0;
        bsy       = 1'b0;
        for (int unsigned p = 0; p < RD_PORTS; p++) begin
            addr = i_rd_addr[rd_lsb(p, ADDR_W) +: ADDR_W];
            data = regs[addr];
            bsy  = busy[addr];
            if (BYPASS != 0 && i_wr_en && i_wr_addr == addr) begin
                data = i_wr_data;
                bsy  = 1'b0;
            end
            if (ZERO_REG != 0 && addr == '0) begin
                data = '0;
                bsy  = 1'b0;
            end
            o_rd_data[rd_lsb(p, DATA_W) +: DATA_W] = data;
            o_rd_busy[p] = bsy;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: default instance (BYPASS=1, ZERO_REG=1)
// plus a BYPASS=0, ZERO_REG=0 instance sharing the same stimulus.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data, rd_data_b;
    logic [1:0]  rd_busy, rd_busy_b;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic        rsv_ok, rsv_ok_b;
    logic        flush;
    logic [5:0]  busy_cnt, busy_cnt_b;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    regfile_sb dut (
        .i_clk(clk), .i_rst(rst), .i_rd_addr(rd_addr), .o_rd_data(rd_data),
        .o_rd_busy(rd_busy), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
        .i_wr_data(wr_data), .i_rsv_en(rsv_en), .i_rsv_addr(rsv_addr),
        .o_rsv_ok(rsv_ok), .i_flush(flush), .o_busy_cnt(busy_cnt)
    );

    regfile_sb #(.ZERO_REG(0), .BYPASS(0)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_rd_addr(rd_addr), .o_rd_data(rd_data_b),
        .o_rd_busy(rd_busy_b), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
        .i_wr_data(wr_data), .i_rsv_en(rsv_en), .i_rsv_addr(rsv_addr),
        .o_rsv_ok(rsv_ok_b), .i_flush(flush), .o_busy_cnt(busy_cnt_b)
    );

    task automatic want(input string tag, input logic [63:0] v);
        q.push_back('{tag, v});
    endtask

    task automatic got(input logic [63:0] obs);
        exp_t e;
        n_total++;
        if (q.size() == 0) begin
            $error("FAIL scoreboard_empty: got %0h expected <entry>", obs);
        end else begin
            e = q.pop_front();
            assert (obs === e.val) n_pass++;
            else $error("FAIL %s: got %0h expected %0h", e.tag, obs, e.val);
        end
    endtask

    // Advance one clock; inputs are then changed 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0; rsv_en = 1'b0; flush = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
    endtask

    initial begin
        rst = 1'b1; idle(); rd(5, 0);
        wr_addr = '0; wr_data = '0; rsv_addr = '0;
        rsv_en = 1'b1;
        #2;
        want("rst_rsv_ok", 1);   got(rsv_ok);
        rsv_en = 1'b0;
        #10;
        @(negedge clk); rst = 1'b0;
        tick();
        want("rst_data0", 0);    got(rd_data[31:0]);
        want("rst_data1", 0);    got(rd_data[63:32]);
        want("rst_busy", 0);     got(rd_busy);
        want("rst_cnt", 0);      got(busy_cnt);

        // Bypass of a same-cycle write
        rd(7, 0); wr_en = 1'b1; wr_addr = 7; wr_data = 32'hDEADBEEF;
        #1;
        want("byp_data", 32'hDEADBEEF); got(rd_data[31:0]);
        want("nobyp_data", 0);          got(rd_data_b[31:0]);
        tick(); idle(); #1;
        want("arr_data", 32'hDEADBEEF);   got(rd_data[31:0]);
        want("arr_data_b", 32'hDEADBEEF); got(rd_data_b[31:0]);

        // Reserve, refused WAW, writeback release
        rd(3, 0); rsv_en = 1'b1; rsv_addr = 3; #1;
        want("rsv3_ok", 1); got(rsv_ok);
        tick(); #1;
        want("rsv3_busy", 1);  got(rd_busy[0]);
        want("rsv3_cnt", 1);   got(busy_cnt);
        want("rsv3_again_ok", 0); got(rsv_ok);
        tick(); idle(); #1;
        want("rsv3_again_cnt", 1); got(busy_cnt);
        wr_en = 1'b1; wr_addr = 3; wr_data = 32'h12; #1;
        want("wr3_byp_busy", 0); got(rd_busy[0]);
        tick(); idle(); #1;
        want("wr3_busy", 0);    got(rd_busy[0]);
        want("wr3_cnt", 0);     got(busy_cnt);
        want("wr3_data", 32'h12); got(rd_data[31:0]);

        // Write and reserve of an already busy register in one cycle
        rsv_en = 1'b1; rsv_addr = 9; tick(); idle(); rd(9, 0); #1;
        want("rsv9_cnt", 1); got(busy_cnt);
        wr_en = 1'b1; wr_addr = 9; wr_data = 32'h99;
        rsv_en = 1'b1; rsv_addr = 9; #1;
        want("wr_rsv9_ok", 1); got(rsv_ok);
        tick(); idle(); #1;
        want("wr_rsv9_data", 32'h99); got(rd_data[31:0]);
        want("wr_rsv9_busy", 1);      got(rd_busy[0]);
        want("wr_rsv9_cnt", 1);       got(busy_cnt);
        wr_en = 1'b1; wr_addr = 9; wr_data = 32'h100;
        tick(); idle(); #1;
        want("wr9_cnt", 0); got(busy_cnt);

        // Register 0: hardwired zero vs plain register
        rd(7, 0); wr_en = 1'b1; wr_addr = 0; wr_data = 32'hFFFF_FFFF;
        rsv_en = 1'b1; rsv_addr = 0; #1;
        want("r0_rsv_ok", 1);    got(rsv_ok);
        want("r0_byp_data", 0);  got(rd_data[63:32]);
        tick(); idle(); #1;
        want("r0_data", 0);      got(rd_data[63:32]);
        want("r0_busy", 0);      got(rd_busy[1]);
        want("r0_cnt", 0);       got(busy_cnt);
        want("r0_data_b", 32'hFFFF_FFFF); got(rd_data_b[63:32]);
        want("r0_cnt_b", 1);     got(busy_cnt_b);

        // Flush wins over a reservation; the write still commits
        rsv_en = 1'b1; rsv_addr = 1; tick();
        rsv_addr = 2; tick();
        rsv_addr = 4; tick(); idle(); rd(2, 4); #1;
        want("pre_flush_cnt", 3); got(busy_cnt);
        want("pre_flush_busy", 2'b11); got(rd_busy);
        flush = 1'b1; rsv_en = 1'b1; rsv_addr = 5;
        wr_en = 1'b1; wr_addr = 2; wr_data = 32'hAA; #1;
        want("flush_rsv_ok", 0); got(rsv_ok);
        tick(); idle(); #1;
        want("flush_cnt", 0);      got(busy_cnt);
        want("flush_busy", 0);     got(rd_busy);
        want("flush_r2", 32'hAA);  got(rd_data[31:0]);
        rd(5, 0); #1;
        want("flush_r5_busy", 0);  got(rd_busy[0]);

        // Asynchronous reset in the middle of a cycle
        rsv_en = 1'b1; rsv_addr = 6; tick(); idle(); rd(6, 7); #1;
        want("pre_rst_cnt", 1);    got(busy_cnt);
        #1; rst = 1'b1; #1;
        want("async_rst_cnt", 0);  got(busy_cnt);
        want("async_rst_busy", 0); got(rd_busy);
        want("async_rst_r7", 0);   got(rd_data[63:32]);
        @(negedge clk); rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
